apb4_protocol_monitor: RTL

Synthesizable, parametrised APB4 bus monitor for the APB4 bridge/slave subsystem with NUM_SLAVES select lines. It tracks the SETUP/ACCESS phase machine on a passive tap of the bus and checks protocol rules: select exclusivity, address-decode consistency, phase ordering, signal stability and wait-state timeout. It reports violations as one-cycle pulses plus sticky flags, and keeps saturating transfer statistics. It drives nothing on the bus and can stay in silicon as a debug/safety observer.

---
 rtl/apb4_protocol_monitor.sv | 138 +++++++++++++
 1 files changed

// File: rtl/apb4_protocol_monitor.sv
// apb4_protocol_monitor: passive APB4 phase tracker and protocol checker
// Inputs : PCLK, PRESETn (sync active-low), APB4 tap (PSEL..PSLVERR), clr
// Outputs: err_valid/err_code pulse, err_sticky, busy, saturating wr/rd/slverr counts, max_wait
module apb4_protocol_monitor #(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [NUM_SLAVES-1:0]   PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  logic                    clr,
    output logic                    err_valid,
    output logic [2:0]              err_code,
    output logic [7:0]              err_sticky,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    wr_count,
    output logic [CNT_WIDTH-1:0]    rd_count,
    output logic [CNT_WIDTH-1:0]    slverr_count,
    output logic [CNT_WIDTH-1:0]    max_wait
);
    localparam int SEL_BITS = $clog2(NUM_SLAVES);
    localparam int WW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] TO = WW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT} state_t;

    state_t                  r_state, w_next;
    logic [NUM_SLAVES-1:0]   r_sel;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_strb;
    logic [2:0]              r_prot;
    logic [WW-1:0]           r_wait, w_wait, w_wait_inc, w_cw;
    logic [7:0]              w_err;
    logic [2:0]              w_code;
    logic [SEL_BITS-1:0]     w_idx;
    logic                    w_cap, w_comp, w_mis;
    logic [CNT_WIDTH-1:0]    w_wr_b, w_rd_b, w_se_b, w_mx_b, w_cw_ext;

    // selected index is the lowest set PSEL bit
    always_comb begin
        w_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if (PSEL[i]) w_idx = SEL_BITS'(i);
    end

    // write data and strobes only matter for writes
    assign w_mis = PSEL != r_sel || PADDR != r_addr || PWRITE != r_write || PPROT != r_prot ||
                   (r_write && (PWDATA != r_wdata || PSTRB != r_strb));
    assign w_wait_inc = r_wait + 1'b1;
    assign w_cw       = r_state == WAIT ? r_wait : '0;

    always_comb begin
        w_err    = '0;
        w_err[0] = |(PSEL & (PSEL - 1'b1));
        w_next   = r_state;
        w_wait   = r_wait;
        w_cap    = 1'b0;
        w_comp   = 1'b0;
        // an aborted SETUP is re-evaluated exactly like IDLE
        if (r_state == IDLE || (r_state == SETUP && !PENABLE)) begin
            w_err[2] = r_state == SETUP;
            w_err[1] = PENABLE;
            w_cap    = PSEL != '0 && !PENABLE;
            w_next   = w_cap ? SETUP : IDLE;
            w_err[5] = w_cap && !PWRITE && PSTRB != '0;
            w_err[6] = w_cap && w_idx != PADDR[ADDR_WIDTH-1 -: SEL_BITS];
        end else if (!PENABLE) begin
            w_err[2] = 1'b1;
            w_next   = IDLE;
        end else begin
            w_err[3] = w_mis;
            w_err[7] = PSLVERR && !PREADY;
            w_comp   = PREADY;
            w_err[4] = !PREADY && (r_state == SETUP ? TIMEOUT_CYCLES == 1 : w_wait_inc == TO);
            w_next   = (PREADY || w_err[4]) ? IDLE : WAIT;
            w_wait   = r_state == SETUP ? WW'(1) : w_wait_inc;
        end
    end

    always_comb begin
        w_code = '0;
        for (int i = 7; i >= 0; i--)
            if (w_err[i]) w_code = 3'(i);
    end

    // clr zeroes the base so a same-cycle event lands on top of the clear
    assign w_wr_b   = clr ? '0 : wr_count;
    assign w_rd_b   = clr ? '0 : rd_count;
    assign w_se_b   = clr ? '0 : slverr_count;
    assign w_mx_b   = clr ? '0 : max_wait;
    assign w_cw_ext = CNT_WIDTH'(w_cw);
    assign busy     = r_state != IDLE;

    always_ff @(posedge PCLK) begin
        if (w_cap) begin
            r_sel   <= PSEL;
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_strb  <= PSTRB;
            r_prot  <= PPROT;
        end
        if (!PRESETn) begin
            r_state      <= IDLE;
            r_wait       <= '0;
            err_valid    <= 1'b0;
            err_code     <= '0;
            err_sticky   <= '0;
            wr_count     <= '0;
            rd_count     <= '0;
            slverr_count <= '0;
            max_wait     <= '0;
        end else begin
            r_state      <= w_next;
            r_wait       <= w_wait;
            err_valid    <= |w_err;
            err_code     <= w_code;
            err_sticky   <= (clr ? 8'h00 : err_sticky) | w_err;
            wr_count     <= w_wr_b + CNT_WIDTH'(w_comp && r_write && !(&w_wr_b));
            rd_count     <= w_rd_b + CNT_WIDTH'(w_comp && !r_write && !(&w_rd_b));
            slverr_count <= w_se_b + CNT_WIDTH'(w_comp && PSLVERR && !(&w_se_b));
            max_wait     <= (w_comp && w_cw_ext > w_mx_b) ? w_cw_ext : w_mx_b;
        end
    end
endmodule
